instr_rom_loader: RTL and testbench

//  Instruction-memory responder for the 8-bit CPU fetch port: accepts a program as a

---
 rtl/instr_rom_loader_if.sv | 22 ++
 rtl/instr_rom_loader.sv | 74 +++++++
 tb/tb_instr_rom_loader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_rom_loader_if.sv
// instr_rom_loader_if: program-load handshake plus CPU fetch port of the instruction ROM loader.
interface instr_rom_loader_if;
    logic       load_start;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic       load_last;
    logic [7:0] readingAddress;
    logic [7:0] instruction;
    logic       cpu_reset;
    logic       loaded;
    logic       load_error;
    logic [8:0] prog_len;
    modport master (
        output load_start, load_valid, load_data, load_last, readingAddress,
        input  load_ready, instruction, cpu_reset, loaded, load_error, prog_len
    );
    modport slave (
        input  load_start, load_valid, load_data, load_last, readingAddress,
        output load_ready, instruction, cpu_reset, loaded, load_error, prog_len
    );
endinterface

// File: rtl/instr_rom_loader.sv
// instr_rom_loader: loads a program byte stream into instruction memory, then serves CPU fetches.
// The CPU is held in reset from load start until RELEASE_DELAY cycles after the last byte.
module instr_rom_loader #(
    parameter int         DEPTH         = 256,
    parameter logic [7:0] FILL          = 8'h00,
    parameter int         RELEASE_DELAY = 2
) (
    input logic CLK,
    input logic reset,
    instr_rom_loader_if.slave bus
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = RELEASE_DELAY > 1 ? $clog2(RELEASE_DELAY) : 1;
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, RELEASE = 3'd2, RUN = 3'd3, ERROR = 3'd4;
    logic [2:0]    state;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [8:0]    prog_len;
    logic          load_error;
    logic          accept;
    logic          addr_ok;
    logic [7:0]    mem [DEPTH];
    assign accept = state == LOAD && bus.load_valid;
    // Upper address bits beyond the array must be zero for a hit.
    assign addr_ok = (bus.readingAddress >> AW) == 8'd0 && {1'b0, bus.readingAddress} < prog_len;
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            count      <= '0;
            prog_len   <= '0;
            load_error <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        wr_ptr   <= wr_ptr + 1'b1;
                        prog_len <= prog_len + 9'd1;
                        if (bus.load_last) begin
                            state <= RELEASE;
                            count <= '0;
                        end else if (wr_ptr == AW'(DEPTH - 1)) begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    if (count == CW'(RELEASE_DELAY - 1)) state <= RUN;
                    else count <= count + 1'b1;
                end
                IDLE, RUN, ERROR: begin
                    if (bus.load_start) begin
                        state      <= LOAD;
                        wr_ptr     <= '0;
                        prog_len   <= '0;
                        load_error <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Program storage deliberately survives reset.
    always_ff @(posedge CLK) begin
        if (accept) mem[wr_ptr] <= bus.load_data;
    end
    assign bus.load_ready  = state == LOAD;
    assign bus.cpu_reset   = state != RUN;
    assign bus.loaded      = state == RUN;
    assign bus.load_error  = load_error;
    assign bus.prog_len    = prog_len;
    assign bus.instruction = (state == RUN && addr_ok) ? mem[bus.readingAddress[AW-1:0]] : FILL;
endmodule

// File: tb/tb_instr_rom_loader.sv
// tb_instr_rom_loader: randomized load/fetch stimulus on a DEPTH=256 and a DEPTH=16 loader,
// checked cycle by cycle against a queue-based program model.
module tb_instr_rom_loader;
    localparam logic [7:0] FILL = 8'h00;
    logic CLK = 0, rst_a = 0, rst_b = 0;
    logic start = 0, valid = 0, last = 0;
    logic [7:0] data = 0, addr = 0;
    logic sel = 0;
    logic o_ready, o_crst, o_loaded, o_err;
    logic [8:0] o_len;
    logic [7:0] o_instr;
    logic [7:0] pbuf [0:63];
    logic [7:0] prog [$];
    bit m_load, m_run, m_err;
    int m_rel, dep, tests, fails;

    instr_rom_loader_if ifa ();
    instr_rom_loader_if ifb ();
    assign ifa.load_start = start & ~sel;
    assign ifa.load_valid = valid & ~sel;
    assign ifa.load_data = data;
    assign ifa.load_last = last;
    assign ifa.readingAddress = addr;
    assign ifb.load_start = start & sel;
    assign ifb.load_valid = valid & sel;
    assign ifb.load_data = data;
    assign ifb.load_last = last;
    assign ifb.readingAddress = addr;
    assign o_ready = sel ? ifb.load_ready : ifa.load_ready;
    assign o_crst = sel ? ifb.cpu_reset : ifa.cpu_reset;
    assign o_loaded = sel ? ifb.loaded : ifa.loaded;
    assign o_err = sel ? ifb.load_error : ifa.load_error;
    assign o_len = sel ? ifb.prog_len : ifa.prog_len;
    assign o_instr = sel ? ifb.instruction : ifa.instruction;

    instr_rom_loader #(.DEPTH(256), .FILL(FILL), .RELEASE_DELAY(2)) dut_a (.CLK(CLK), .reset(rst_a), .bus(ifa.slave));
    instr_rom_loader #(.DEPTH(16), .FILL(FILL), .RELEASE_DELAY(2)) dut_b (.CLK(CLK), .reset(rst_b), .bus(ifb.slave));

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_instr(input int a);
        return (m_run && a < prog.size()) ? prog[a] : FILL;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".ready"}, o_ready, m_load);
        check({tag, ".cpu_reset"}, o_crst, !m_run);
        check({tag, ".loaded"}, o_loaded, m_run);
        check({tag, ".error"}, o_err, m_err);
        check({tag, ".len"}, o_len, prog.size());
        check({tag, ".instr"}, o_instr, exp_instr(addr));
    endtask

    // Model: the program is the queue of accepted bytes; the CPU runs two cycles after the last one.
    task automatic tick();
        if (m_load) begin
            if (valid) begin
                prog.push_back(data);
                if (last) begin
                    m_load = 0;
                    m_rel = 2;
                end else if (prog.size() == dep) begin
                    m_load = 0;
                    m_err = 1;
                end
            end
        end else if (m_rel > 0) begin
            m_rel--;
            m_run = (m_rel == 0);
        end else if (start) begin
            m_run = 0;
            m_err = 0;
            prog.delete();
            m_load = 1;
        end
        @(posedge CLK);
        #1;
        check_all("cyc");
    endtask

    task automatic do_reset();
        if (sel) rst_b = 0;
        else rst_a = 0;
        start = 0;
        valid = 0;
        last = 0;
        #2;
        m_load = 0;
        m_run = 0;
        m_err = 0;
        m_rel = 0;
        prog.delete();
        check_all("rst");
        #1;
        if (sel) rst_b = 1;
        else rst_a = 1;
    endtask

    task automatic peek(input int a);
        addr = 8'(a);
        #1;
        check("fetch", o_instr, exp_instr(a));
    endtask

    // gaps: 0 none, 1 an idle cycle before every byte after the first, 2 random idle cycles
    task automatic send(input int n, input int gaps, input bit mark_last);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && (gaps == 1 || (gaps == 2 && $urandom_range(1, 0) == 1))) begin
                valid = 0;
                data = 8'($urandom);
                last = 1'($urandom);
                tick();
            end
            valid = 1;
            data = pbuf[i];
            last = mark_last && i == n - 1;
            tick();
        end
        valid = 0;
        last = 0;
        data = 8'($urandom);
    endtask

    task automatic load(input int n, input int gaps);
        start = 1;
        tick();
        start = 0;
        send(n, gaps, 1);
        repeat (3) tick();
    endtask

    task automatic fill_demo();
        for (int i = 0; i < 20; i++) begin
            logic [31:0] pat;
            pat = 32'h44491984;
            pbuf[i] = pat[8*(3-i%4) +: 8];
        end
        pbuf[20] = 8'hC3;
    endtask

    initial begin
        sel = 0;
        dep = 256;
        do_reset();
        tick();

        fill_demo();
        start = 1;
        tick();
        start = 0;
        send(21, 0, 1);
        check("t1.hold0", o_crst, 1);
        tick();
        check("t1.hold1", o_crst, 1);
        tick();
        check("t1.release", o_crst, 0);
        check("t1.len", o_len, 21);
        addr = 3;
        #1 check("t1.a3", o_instr, 8'h84);
        addr = 20;
        #1 check("t1.a20", o_instr, 8'hC3);
        addr = 21;
        #1 check("t1.a21", o_instr, FILL);
        for (int i = 0; i < 12; i++) peek($urandom_range(30, 0));

        do_reset();
        load(21, 1);
        check("t2.len", o_len, 21);
        for (int i = 0; i < 22; i++) peek(i);

        sel = 1;
        dep = 16;
        do_reset();
        for (int i = 0; i < 17; i++) pbuf[i] = 8'($urandom);
        start = 1;
        tick();
        start = 0;
        send(17, 0, 1);
        check("t3.error", o_err, 1);
        check("t3.cpu_reset", o_crst, 1);
        check("t3.len", o_len, 16);
        start = 1;
        tick();
        start = 0;
        check("t3.err_clear", o_err, 0);
        check("t3.reload", o_ready, 1);
        for (int i = 0; i < 16; i++) pbuf[i] = 8'($urandom);
        send(16, 0, 1);
        repeat (3) tick();
        check("t4.len", o_len, 16);
        check("t4.loaded", o_loaded, 1);
        addr = 15;
        #1 check("t4.a15", o_instr, pbuf[15]);
        peek(16);
        peek(255);

        sel = 0;
        dep = 256;
        do_reset();
        for (int i = 0; i < 10; i++) pbuf[i] = 8'($urandom);
        start = 1;
        tick();
        start = 0;
        send(5, 0, 0);
        do_reset();
        check("t5.len", o_len, 0);
        check("t5.instr", o_instr, FILL);
        tick();
        load(3, 0);
        for (int i = 0; i < 4; i++) peek(i);

        start = 1;
        tick();
        start = 0;
        check("t6.cpu_reset", o_crst, 1);
        pbuf[0] = 8'hAA;
        pbuf[1] = 8'hBB;
        send(2, 0, 1);
        repeat (3) tick();
        addr = 0;
        #1 check("t6.a0", o_instr, 8'hAA);
        addr = 1;
        #1 check("t6.a1", o_instr, 8'hBB);
        addr = 2;
        #1 check("t6.a2", o_instr, FILL);

        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            dep = s ? 16 : 256;
            do_reset();
            for (int k = 0; k < 6; k++) begin
                int n;
                n = s ? $urandom_range(20, 1) : $urandom_range(60, 1);
                for (int i = 0; i < n; i++) pbuf[i] = 8'($urandom);
                load(n, 2);
                for (int i = 0; i < 10; i++) peek($urandom_range(s ? 31 : 70, 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
